// File: rtl/smpl_buf_ctrl.sv
// ---------------------------------------------------------------------------
// smpl_buf_ctrl
//
// Circular sample-buffer controller sitting between the capture FSM and a
// single-port sample RAM (the RAM array is inferred inside this module).
//
// The write side stores every strobed sample at the write pointer and keeps
// going forever, overwriting the oldest sample once the buffer is full.
// The read side walks backwards from the newest sample, one sample per read
// strobe, and returns the data one cycle after the strobe.
//
// Ports
//   clk_i   in   1             system clock, rising edge
//   rst_i   in   1             asynchronous reset, active high
//   clr_i   in   1             synchronous clear of pointers/counters/flags
//   wrt_i   in   1             write strobe, store data_i this cycle
//   data_i  in   SMPL_WIDTH    sample to store
//   rd_i    in   1             read strobe, fetch the next-older sample
//   data_o  out  SMPL_WIDTH    read data, valid while vld_o is high
//   vld_o   out  1             one-cycle pulse following each accepted rd_i
//   fill_o  out  ADDR_WIDTH+1  number of stored samples, saturates at DEPTH
//   full_o  out  1             fill_o == DEPTH
//   udf_o   out  1             sticky: a read found no unread sample left
//
// Per-cycle priority is clr_i > wrt_i > rd_i. A read issued in the same
// cycle as a write is dropped entirely, which also keeps the single RAM
// port free of read/write collisions.
// ---------------------------------------------------------------------------
module smpl_buf_ctrl #(
    parameter int SMPL_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  wrt_i,
    input  logic [SMPL_WIDTH-1:0] data_i,
    input  logic                  rd_i,
    output logic [SMPL_WIDTH-1:0] data_o,
    output logic                  vld_o,
    output logic [ADDR_WIDTH:0]   fill_o,
    output logic                  full_o,
    output logic                  udf_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   FILL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        MODE_WR = 1'b0,
        MODE_RD = 1'b1
    } mode_t;

    // Sample storage; deliberately not reset.
    logic [SMPL_WIDTH-1:0] r_mem [DEPTH];

    // Registered state.
    mode_t                 r_mode;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_rem;
    logic [ADDR_WIDTH:0]   r_fill;
    logic [SMPL_WIDTH-1:0] r_data;
    logic                  r_vld;
    logic                  r_udf;

    // Next-state values.
    mode_t                 w_mode_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_rem_nxt;
    logic [ADDR_WIDTH:0]   w_fill_nxt;
    logic [SMPL_WIDTH-1:0] w_data_nxt;
    logic                  w_vld_nxt;
    logic                  w_udf_nxt;

    // Decoded strobes and read addressing.
    logic                  w_we;
    logic                  w_rd_req;
    logic                  w_avail;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH:0]   w_rem_after;
    logic [SMPL_WIDTH-1:0] w_ram_q;

    assign w_we     = wrt_i & ~clr_i;
    assign w_rd_req = rd_i & ~wrt_i & ~clr_i;

    // A fresh read sequence (mode WR) starts just below the write pointer and
    // counts the whole fill; a continuing sequence steps below the previous
    // read address and counts down what is left of that sequence.
    always_comb begin
        w_avail     = 1'b0;
        w_rd_addr   = '0;
        w_rem_after = '0;
        if (r_mode == MODE_WR) begin
            w_avail     = (r_fill != CNT_ZERO);
            w_rd_addr   = r_wr_ptr - PTR_ONE;
            w_rem_after = r_fill - CNT_ONE;
        end else begin
            w_avail     = (r_rem != CNT_ZERO);
            w_rd_addr   = r_rd_ptr - PTR_ONE;
            w_rem_after = r_rem - CNT_ONE;
        end
    end

    assign w_ram_q = r_mem[w_rd_addr];

    // Single RAM port: write only. Reads use w_ram_q, and a read is never
    // issued in a write cycle.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_mode_nxt   = r_mode;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_rem_nxt    = r_rem;
        w_fill_nxt   = r_fill;
        w_data_nxt   = r_data;
        w_vld_nxt    = 1'b0;
        w_udf_nxt    = r_udf;

        if (clr_i) begin
            w_mode_nxt   = MODE_WR;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_rem_nxt    = '0;
            w_fill_nxt   = '0;
            w_data_nxt   = '0;
            w_udf_nxt    = 1'b0;
        end else if (wrt_i) begin
            // Any read sequence in progress is abandoned; the next read
            // restarts from the sample written here.
            w_mode_nxt   = MODE_WR;
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            if (r_fill != FILL_MAX) begin
                w_fill_nxt = r_fill + CNT_ONE;
            end
        end else if (rd_i) begin
            w_mode_nxt = MODE_RD;
            w_vld_nxt  = 1'b1;
            if (w_avail) begin
                w_rd_ptr_nxt = w_rd_addr;
                w_rem_nxt    = w_rem_after;
                w_data_nxt   = w_ram_q;
            end else begin
                // Underflow still answers the strobe, with zero data.
                w_data_nxt = '0;
                w_udf_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode   <= MODE_WR;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rem    <= '0;
            r_fill   <= '0;
            r_data   <= '0;
            r_vld    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_mode   <= w_mode_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_rem    <= w_rem_nxt;
            r_fill   <= w_fill_nxt;
            r_data   <= w_data_nxt;
            r_vld    <= w_vld_nxt;
            r_udf    <= w_udf_nxt;
        end
    end

    assign data_o = r_data;
    assign vld_o  = r_vld;
    assign fill_o = r_fill;
    assign full_o = (r_fill == FILL_MAX);
    assign udf_o  = r_udf;

    // w_rd_req is kept as the documented read-accept condition; it must
    // always agree with the branch that raises vld.
    logic w_unused_ok;
    assign w_unused_ok = (w_rd_req == w_vld_nxt);

endmodule

// File: tb/tb_smpl_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smpl_buf_ctrl
//
// Directed bench for smpl_buf_ctrl with a 4-entry buffer (ADDR_WIDTH=2) so
// that wrap-around, saturation and underflow are all reachable quickly.
// Inputs change #1 after a rising edge; outputs are checked at that point,
// i.e. they reflect the state registered on the preceding edge.
// ---------------------------------------------------------------------------
module tb_smpl_buf_ctrl;

    localparam int SW = 32;
    localparam int AW = 2;

    logic          clk_i  = 1'b0;
    logic          rst_i  = 1'b1;
    logic          clr_i  = 1'b0;
    logic          wrt_i  = 1'b0;
    logic [SW-1:0] data_i = '0;
    logic          rd_i   = 1'b0;
    logic [SW-1:0] data_o;
    logic          vld_o;
    logic [AW:0]   fill_o;
    logic          full_o;
    logic          udf_o;

    int n_chk  = 0;
    int n_pass = 0;

    smpl_buf_ctrl #(
        .SMPL_WIDTH (SW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .wrt_i  (wrt_i),
        .data_i (data_i),
        .rd_i   (rd_i),
        .data_o (data_o),
        .vld_o  (vld_o),
        .fill_o (fill_o),
        .full_o (full_o),
        .udf_o  (udf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        clr_i = 1'b0;
        wrt_i = 1'b0;
        rd_i  = 1'b0;
    endtask

    task automatic wr(input logic [SW-1:0] d);
        idle();
        wrt_i  = 1'b1;
        data_i = d;
        tick();
        idle();
    endtask

    task automatic clear();
        idle();
        clr_i = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        // 1: reset held with rd_i high
        rd_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_vld",  {31'd0, vld_o}, 32'd0);
            chk("rst_fill", {29'd0, fill_o}, 32'd0);
            chk("rst_udf",  {31'd0, udf_o}, 32'd0);
        end
        chk("rst_data", data_o, 32'd0);
        chk("rst_full", {31'd0, full_o}, 32'd0);
        rd_i  = 1'b0;
        rst_i = 1'b0;
        tick();
        chk("post_rst_vld", {31'd0, vld_o}, 32'd0);

        // 2: three writes, three back-to-back reads, newest first
        wr(32'h11);
        wr(32'h22);
        wr(32'h33);
        chk("t2_fill", {29'd0, fill_o}, 32'd3);
        rd_i = 1'b1;
        tick();
        chk("t2_vld0",  {31'd0, vld_o}, 32'd1);
        chk("t2_data0", data_o, 32'h33);
        tick();
        chk("t2_vld1",  {31'd0, vld_o}, 32'd1);
        chk("t2_data1", data_o, 32'h22);
        tick();
        chk("t2_vld2",  {31'd0, vld_o}, 32'd1);
        chk("t2_data2", data_o, 32'h11);
        rd_i = 1'b0;
        tick();
        chk("t2_vld_end", {31'd0, vld_o}, 32'd0);
        chk("t2_fill_kept", {29'd0, fill_o}, 32'd3);

        // 3: wrap-around and saturation
        clear();
        chk("clr_fill", {29'd0, fill_o}, 32'd0);
        chk("clr_data", data_o, 32'd0);
        for (int i = 1; i <= 6; i++) wr(32'(i));
        chk("t3_fill", {29'd0, fill_o}, 32'd4);
        chk("t3_full", {31'd0, full_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_i = 1'b1;
            tick();
            chk("t3_vld",  {31'd0, vld_o}, 32'd1);
            chk("t3_data", data_o, 32'(6 - i));
        end

        // 4: underflow after the sequence is exhausted
        tick();
        chk("t4_vld",  {31'd0, vld_o}, 32'd1);
        chk("t4_data", data_o, 32'd0);
        chk("t4_udf",  {31'd0, udf_o}, 32'd1);
        rd_i = 1'b0;
        tick();
        tick();
        chk("t4_udf_sticky", {31'd0, udf_o}, 32'd1);
        chk("t4_vld_idle",   {31'd0, vld_o}, 32'd0);
        chk("t4_full_kept",  {31'd0, full_o}, 32'd1);
        clear();
        chk("t4_udf_clr",  {31'd0, udf_o}, 32'd0);
        chk("t4_fill_clr", {29'd0, fill_o}, 32'd0);
        chk("t4_full_clr", {31'd0, full_o}, 32'd0);

        // clr one cycle after a read strobe: the read still answers, the
        // clear then wipes the output registers
        wr(32'h77);
        rd_i = 1'b1;
        tick();
        chk("clr_rd_vld",  {31'd0, vld_o}, 32'd1);
        chk("clr_rd_data", data_o, 32'h77);
        rd_i  = 1'b1;
        clr_i = 1'b1;
        tick();
        chk("clr_pri_vld",  {31'd0, vld_o}, 32'd0);
        chk("clr_pri_data", data_o, 32'd0);
        chk("clr_pri_udf",  {31'd0, udf_o}, 32'd0);
        idle();

        // 5: a write mid-sequence restarts reading from the newest sample
        wr(32'hA);
        wr(32'hB);
        rd_i = 1'b1;
        tick();
        chk("t5_rd_b", data_o, 32'hB);
        wr(32'hC);
        rd_i = 1'b1;
        tick();
        chk("t5_rd_c",  data_o, 32'hC);
        chk("t5_vld_c", {31'd0, vld_o}, 32'd1);
        tick();
        chk("t5_rd_b2", data_o, 32'hB);
        idle();
        tick();

        // 6: simultaneous write and read, write wins
        chk("t6_fill_before", {29'd0, fill_o}, 32'd3);
        wrt_i  = 1'b1;
        rd_i   = 1'b1;
        data_i = 32'h5A;
        tick();
        chk("t6_no_vld", {31'd0, vld_o}, 32'd0);
        chk("t6_fill",   {29'd0, fill_o}, 32'd4);
        chk("t6_udf",    {31'd0, udf_o}, 32'd0);
        idle();
        rd_i = 1'b1;
        tick();
        chk("t6_rd_vld",  {31'd0, vld_o}, 32'd1);
        chk("t6_rd_data", data_o, 32'h5A);

        // async reset asserted mid-read drops vld at once
        rd_i  = 1'b1;
        rst_i = 1'b1;
        #1;
        chk("ar_vld_now",  {31'd0, vld_o}, 32'd0);
        chk("ar_fill_now", {29'd0, fill_o}, 32'd0);
        tick();
        rd_i  = 1'b0;
        rst_i = 1'b0;
        tick();
        chk("ar_no_pulse", {31'd0, vld_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
